// File: rtl/uart_hex_tx_if.sv
// Word-push channel into uart_hex_tx.
//   wdata  : 32-bit word to print
//   wlast  : 1 -> separator CR,LF; 0 -> separator space
//   wvalid : push request from the source
//   wready : sink can take a word (word FIFO not full)
// master modport is the data source, slave modport is uart_hex_tx.
interface uart_hex_tx_if;
  logic [31:0] wdata;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  modport master (output wdata, output wlast, output wvalid, input wready);
  modport slave  (input wdata, input wlast, input wvalid, output wready);
endinterface

// File: rtl/uart_hex_tx.sv
// uart_hex_tx: prints 32-bit words as 8 lowercase ASCII hex characters plus a
// separator (space, or CR,LF) on an 8N1 UART transmit line.
// Word FIFO -> formatter FSM -> bit serialiser.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active high
//   wr         uart_hex_tx_if.slave push channel (wdata, wlast, wvalid, wready)
//   uart_term  bit period in clk cycles (values below 2 behave as 2)
//   tx         serial output, idle high
//   busy       FIFO non-empty, or formatter/serialiser active
//
// Build option
//   UART_HEX_TX_PARITY_EN : adds an even-parity bit between d7 and stop
//                           (11-bit frames instead of 10).
//
// Formatter states
//   state   | meaning
//   IDLE    | nothing to print, waiting for a FIFO entry
//   LOAD    | pop FIFO head into the shift register, offer its top nibble
//   HEX     | offer hex digit for nibble nib (7 down to 0)
//   SEP1    | offer space (wlast=0) or CR (wlast=1)
//   SEP2    | offer LF (wlast=1 only)
module uart_hex_tx #(
  parameter int FIFO_AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  uart_hex_tx_if.slave  wr,
  input  logic [15:0]   uart_term,
  output logic          tx,
  output logic          busy
);

  localparam int DEPTH = 1 << FIFO_AW;

`ifdef UART_HEX_TX_PARITY_EN
  localparam logic [3:0] TAIL_BITS = 4'd10;  // d0..d7, parity, stop
`else
  localparam logic [3:0] TAIL_BITS = 4'd9;   // d0..d7, stop
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEX,
    ST_SEP1,
    ST_SEP2
  } state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    // 'a' + (n - 10) folds to 0x57 + n
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h57 + {4'h0, n};
  endfunction

  // ---------------------------------------------------------------- FIFO
  logic [32:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  logic [32:0]      head;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign wr.wready = !full;
  // Full blocks a push even when a pop happens in the same cycle.
  assign push      = wr.wvalid && !full;
  assign head      = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {wr.wlast, wr.wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ----------------------------------------------------------- formatter
  state_t      state, state_nx;
  logic [31:0] sh_word;
  logic        sh_last;
  logic [2:0]  nib;
  logic [31:0] nib_word;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_acc;
  logic        ser_rdy;

  assign ch_acc = ch_valid && ser_rdy;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    pop      = 1'b0;
    nib_word = sh_word >> {nib, 2'b00};
    case (state)
      ST_IDLE: begin
        if (!empty) state_nx = ST_LOAD;
      end
      // The top digit is offered straight from the FIFO head so a word
      // arriving at an idle block reaches the line without an extra cycle.
      ST_LOAD: begin
        pop      = 1'b1;
        ch_valid = 1'b1;
        ch_data  = hex_char(head[31:28]);
        state_nx = ST_HEX;
      end
      ST_HEX: begin
        ch_valid = 1'b1;
        ch_data  = hex_char(nib_word[3:0]);
        if (ser_rdy && nib == 3'd0) state_nx = ST_SEP1;
      end
      ST_SEP1: begin
        ch_valid = 1'b1;
        ch_data  = sh_last ? 8'h0D : 8'h20;
        if (ser_rdy) begin
          if (sh_last)     state_nx = ST_SEP2;
          else if (!empty) state_nx = ST_LOAD;
          else             state_nx = ST_IDLE;
        end
      end
      ST_SEP2: begin
        ch_valid = 1'b1;
        ch_data  = 8'h0A;
        if (ser_rdy) state_nx = empty ? ST_IDLE : ST_LOAD;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_word <= '0;
      sh_last <= 1'b0;
      nib     <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          sh_word <= head[31:0];
          sh_last <= head[32];
          nib     <= ch_acc ? 3'd6 : 3'd7;
        end
        ST_HEX: if (ch_acc) nib <= nib - 3'd1;
        default: ;
      endcase
    end
  end

  // ----------------------------------------------------------- serialiser
  logic        ser_act;
  logic [9:0]  ser_sh;
  logic [3:0]  ser_left;
  logic [15:0] ser_tim;
  logic [15:0] ser_t;
  logic        tx_q;
  logic [15:0] t_eff;
  logic [9:0]  tail;

  assign t_eff = (uart_term < 16'd2) ? 16'd2 : uart_term;
`ifdef UART_HEX_TX_PARITY_EN
  assign tail  = {1'b1, ^ch_data, ch_data};
`else
  assign tail  = {2'b11, ch_data};
`endif

  // Ready when idle or in the final cycle of the stop bit, so consecutive
  // characters abut with no idle gap.
  assign ser_rdy = !ser_act || (ser_left == 4'd0 && ser_tim == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ser_act  <= 1'b0;
      ser_sh   <= '0;
      ser_left <= '0;
      ser_tim  <= '0;
      ser_t    <= '0;
      tx_q     <= 1'b1;
    end else if (ch_acc) begin
      ser_act  <= 1'b1;
      tx_q     <= 1'b0;
      ser_sh   <= tail;
      ser_left <= TAIL_BITS;
      ser_t    <= t_eff;
      ser_tim  <= t_eff - 16'd1;
    end else if (ser_act) begin
      if (ser_tim == 16'd0) begin
        if (ser_left == 4'd0) begin
          ser_act <= 1'b0;
          tx_q    <= 1'b1;
        end else begin
          tx_q     <= ser_sh[0];
          ser_sh   <= {1'b1, ser_sh[9:1]};
          ser_left <= ser_left - 4'd1;
          ser_tim  <= ser_t - 16'd1;
        end
      end else begin
        ser_tim <= ser_tim - 16'd1;
      end
    end
  end

  assign tx   = tx_q;
  assign busy = !empty || (state != ST_IDLE) || ser_act;

endmodule
